// File: rtl/gcd_pkg.sv
// Shared widths and select encodings for the GCD datapath.
// Optional feature macro used by gcd_datapath: GCD_ITER_COUNT_EN.
package gcd_pkg;

    localparam int GCD_WIDTH  = 16;
    localparam int GCD_ITER_W = 16;

    localparam logic SEL_LOAD = 1'b0;
    localparam logic SEL_SUB  = 1'b1;

endpackage

// File: rtl/gcd_operand_reg.sv
// Load-enable operand register choosing between an external value
// and its own value minus the other operand.
module gcd_operand_reg
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             sel,
    input  logic [WIDTH-1:0] ext_in,
    input  logic [WIDTH-1:0] other,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] d;

    always_comb begin
        d = ext_in;
        if (sel == SEL_SUB)
            d = q - other;
    end

    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (load)
            q <= d;
    end

endmodule

// File: rtl/gcd_datapath.sv
// GCD datapath: operand registers, status flags, zero guard, result.
// Define GCD_ITER_COUNT_EN to add the saturating iter_count output.
module gcd_datapath
    import gcd_pkg::*;
#(
    parameter int WIDTH  = GCD_WIDTH,
    parameter int ITER_W = GCD_ITER_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  A_in,
    input  logic [WIDTH-1:0]  B_in,
    input  logic              A_sel,
    input  logic              B_sel,
    input  logic              AL,
    input  logic              BL,
    input  logic              res_L,
    output logic              equal_val,
    output logic              less_val,
    output logic [WIDTH-1:0]  result,
    output logic              result_valid,
    output logic              zero_operand
`ifdef GCD_ITER_COUNT_EN
    ,
    output logic [ITER_W-1:0] iter_count
`endif
);

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             init_load;
    logic             res_pend;

    assign init_load = AL & BL & (A_sel == SEL_LOAD) & (B_sel == SEL_LOAD);

    gcd_operand_reg #(.WIDTH(WIDTH)) u_a (
        .clk    (clk),
        .rst    (rst),
        .load   (AL),
        .sel    (A_sel),
        .ext_in (A_in),
        .other  (b_reg),
        .q      (a_reg)
    );

    gcd_operand_reg #(.WIDTH(WIDTH)) u_b (
        .clk    (clk),
        .rst    (rst),
        .load   (BL),
        .sel    (B_sel),
        .ext_in (B_in),
        .other  (a_reg),
        .q      (b_reg)
    );

    // Zero guard lets the controller finish immediately on gcd(0,x).
    assign equal_val = zero_operand | (a_reg == b_reg);
    assign less_val  = a_reg < b_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            zero_operand <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            res_pend     <= 1'b0;
        end else begin
            if (init_load)
                zero_operand <= (A_in == '0) | (B_in == '0);
            if (res_L)
                result <= zero_operand ? (a_reg | b_reg) : a_reg;
            // Valid trails the result write by one clock.
            if (init_load) begin
                result_valid <= 1'b0;
                res_pend     <= 1'b0;
            end else begin
                res_pend <= res_L;
                if (res_pend)
                    result_valid <= 1'b1;
            end
        end
    end

`ifdef GCD_ITER_COUNT_EN
    logic sub_cycle;

    assign sub_cycle = (AL & (A_sel == SEL_SUB)) | (BL & (B_sel == SEL_SUB));

    always_ff @(posedge clk) begin
        if (rst)
            iter_count <= '0;
        else if (init_load)
            iter_count <= '0;
        else if (sub_cycle && (iter_count != '1))
            iter_count <= iter_count + 1'b1;
    end
`endif

endmodule

// File: tb/tb_gcd_datapath.sv
// Self-checking bench for gcd_datapath with a bench-side controller,
// vector table and result scoreboard.
module tb_gcd_datapath;

    localparam int W  = 16;
    localparam int IW = 16;

    logic          clk;
    logic          rst;
    logic [W-1:0]  A_in;
    logic [W-1:0]  B_in;
    logic          A_sel;
    logic          B_sel;
    logic          AL;
    logic          BL;
    logic          res_L;
    logic          equal_val;
    logic          less_val;
    logic [W-1:0]  result;
    logic          result_valid;
    logic          zero_operand;
`ifdef GCD_ITER_COUNT_EN
    logic [IW-1:0] iter_count;
`endif

    gcd_datapath #(.WIDTH(W), .ITER_W(IW)) dut (
        .clk          (clk),
        .rst          (rst),
        .A_in         (A_in),
        .B_in         (B_in),
        .A_sel        (A_sel),
        .B_sel        (B_sel),
        .AL           (AL),
        .BL           (BL),
        .res_L        (res_L),
        .equal_val    (equal_val),
        .less_val     (less_val),
        .result       (result),
        .result_valid (result_valid),
        .zero_operand (zero_operand)
`ifdef GCD_ITER_COUNT_EN
        ,
        .iter_count   (iter_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_res;
        logic         exp_zero;
        int           exp_iter;
    } vec_t;

    vec_t          vecs[$];
    logic [W-1:0]  sb[$];
    int            nvec;
    int            nerr;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] gcd_model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x = a;
        logic [W-1:0] y = b;
        logic [W-1:0] t;
        if (x == 0) return y;
        if (y == 0) return x;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic int iter_model(input logic [W-1:0] a, input logic [W-1:0] b);
        int x = int'(a);
        int y = int'(b);
        int n = 0;
        if (x == 0 || y == 0) return 0;
        while (x != y) begin
            if (x < y) y = y - x;
            else       x = x - y;
            n++;
        end
        return n;
    endfunction

    task automatic idle();
        AL    = 1'b0;
        BL    = 1'b0;
        A_sel = 1'b0;
        B_sel = 1'b0;
        res_L = 1'b0;
    endtask

    task automatic load_pair(input logic [W-1:0] a, input logic [W-1:0] b);
        A_in = a;
        B_in = b;
        AL   = 1'b1;
        BL   = 1'b1;
        step();
        idle();
    endtask

    task automatic sub_once();
        if (less_val) begin
            BL    = 1'b1;
            B_sel = 1'b1;
        end else begin
            AL    = 1'b1;
            A_sel = 1'b1;
        end
        step();
        idle();
    endtask

    task automatic run_gcd(input vec_t v);
        int n;
        logic [W-1:0] exp_r;
        load_pair(v.a, v.b);
        sb.push_back(v.exp_res);
        check("zero_operand", zero_operand, v.exp_zero);
        check("valid_after_load", result_valid, 0);
        check("equal_after_load", equal_val, (v.a == v.b) || v.exp_zero);
        check("less_after_load", less_val, v.a < v.b);
        n = 0;
        while (!equal_val && n < 5000) begin
            sub_once();
            n++;
        end
        if (!equal_val) check("iter_timeout", n, -1);
        res_L = 1'b1;
        step();
        res_L = 1'b0;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            exp_r = sb.pop_front();
            check("result", result, exp_r);
        end
        check("valid_same_edge", result_valid, 0);
        step();
        check("valid_next_edge", result_valid, 1);
`ifdef GCD_ITER_COUNT_EN
        check("iter_count", iter_count, v.exp_iter);
`endif
    endtask

    function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b);
        vec_t v;
        v.a        = a;
        v.b        = b;
        v.exp_res  = gcd_model(a, b);
        v.exp_zero = (a == 0) || (b == 0);
        v.exp_iter = iter_model(a, b);
        return v;
    endfunction

    initial begin
        nvec = 0;
        nerr = 0;
        A_in = '0;
        B_in = '0;
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_result", result, 0);
        check("rst_valid", result_valid, 0);
        check("rst_zero", zero_operand, 0);
        check("rst_equal", equal_val, 1);
        check("rst_less", less_val, 0);

        vecs.push_back(mk(16'd12, 16'd18));
        vecs.push_back(mk(16'd7, 16'd7));
        vecs.push_back(mk(16'd0, 16'd9));
        vecs.push_back(mk(16'd0, 16'd0));
        vecs.push_back(mk(16'd13, 16'd8));
        vecs.push_back(mk(16'd35, 16'd14));
        vecs.push_back(mk(16'd9, 16'd0));
        vecs.push_back(mk(16'hFFFF, 16'hFFFF));
        vecs.push_back(mk(16'd1000, 16'd1));
        vecs.push_back(mk(16'd270, 16'd192));
        check("model_12_18", vecs[0].exp_res, 6);
        check("model_13_8_iter", vecs[4].exp_iter, 5);

        foreach (vecs[i]) run_gcd(vecs[i]);

        // Reset in the middle of 48,36 then rerun it.
        load_pair(16'd48, 16'd36);
        sub_once();
        check("mid_less", less_val, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_result", result, 0);
        check("midrst_valid", result_valid, 0);
        check("midrst_equal", equal_val, 1);
        check("midrst_less", less_val, 0);
        check("midrst_zero", zero_operand, 0);
`ifdef GCD_ITER_COUNT_EN
        check("midrst_iter", iter_count, 0);
`endif
        run_gcd(mk(16'd48, 16'd36));

        // Reset wins over a simultaneous load.
        A_in = 16'd5;
        B_in = 16'd3;
        AL   = 1'b1;
        BL   = 1'b1;
        rst  = 1'b1;
        step();
        rst = 1'b0;
        idle();
        check("rstprio_equal", equal_val, 1);
        check("rstprio_less", less_val, 0);
        check("rstprio_valid", result_valid, 0);

        // Back-to-back: 12,18 then 35,14 without reset.
        run_gcd(mk(16'd12, 16'd18));
        run_gcd(mk(16'd35, 16'd14));

        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
